// File: rtl/mem_stage_pkg.sv
// Shared widths, encodings and MEM pipeline register payload for the memory stage.
package mem_stage_pkg;

  localparam int unsigned WORD_DATA_W = 32;
  localparam int unsigned WORD_ADDR_W = 30;
  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned MEM_OP_W    = 2;
  localparam int unsigned CTRL_OP_W   = 2;
  localparam int unsigned ISA_EXP_W   = 3;
  localparam int unsigned BYTE_OFS_W  = 2;

  localparam logic [MEM_OP_W-1:0] MEM_OP_NOP = 2'd0;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LDW = 2'd1;
  localparam logic [MEM_OP_W-1:0] MEM_OP_STW = 2'd2;

  localparam logic [CTRL_OP_W-1:0] CTRL_OP_NOP = 2'd0;

  localparam logic [ISA_EXP_W-1:0] ISA_EXP_NO_EXP     = 3'd0;
  localparam logic [ISA_EXP_W-1:0] ISA_EXP_MISS_ALIGN = 3'd4;

  localparam logic BUS_READ  = 1'b1;
  localparam logic BUS_WRITE = 1'b0;

  typedef enum logic [1:0] {
    MEM_STATE_IDLE   = 2'd0,
    MEM_STATE_REQ    = 2'd1,
    MEM_STATE_ACCESS = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [WORD_ADDR_W-1:0] pc;
    logic                   en;
    logic                   br_flag;
    logic [CTRL_OP_W-1:0]   ctrl_op;
    logic [REG_ADDR_W-1:0]  dst_addr;
    logic                   gpr_we_;
    logic [ISA_EXP_W-1:0]   exp_code;
    logic [WORD_DATA_W-1:0] out;
  } mem_reg_t;

  // Pipeline bubble: invalid, no register write, no exception.
  function automatic mem_reg_t mem_bubble();
    mem_reg_t b;
    b.pc       = '0;
    b.en       = 1'b0;
    b.br_flag  = 1'b0;
    b.ctrl_op  = CTRL_OP_NOP;
    b.dst_addr = '0;
    b.gpr_we_  = 1'b1;
    b.exp_code = ISA_EXP_NO_EXP;
    b.out      = '0;
    return b;
  endfunction

endpackage

// File: rtl/mem_stage_bus_if.sv
// Bus master: request/grant/ready handshake FSM with registered bus outputs and read-data capture.
module bus_if
  import mem_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   acc,
  input  logic                   flush,
  input  logic [MEM_OP_W-1:0]    mem_op,
  input  logic [WORD_ADDR_W-1:0] addr,
  input  logic [WORD_DATA_W-1:0] wr_data,
  input  logic [WORD_DATA_W-1:0] bus_rd_data,
  input  logic                   bus_rdy_,
  input  logic                   bus_grnt_,
  output logic                   bus_req_,
  output logic                   bus_as_,
  output logic                   bus_rw,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  output logic [WORD_DATA_W-1:0] bus_wr_data,
  output mem_state_e             state,
  output logic [WORD_DATA_W-1:0] rd_data_c
);

  logic [WORD_DATA_W-1:0] rd_data_q;
  logic                   done_c;

  // Completing access: ACCESS with ready sampled low.
  assign done_c    = (state == MEM_STATE_ACCESS) && !bus_rdy_;
  // Read data is forwarded in the completion cycle so the MEM register loads on that edge.
  assign rd_data_c = done_c ? bus_rd_data : rd_data_q;

  // Handshake FSM; bus address/direction/data are latched when the request is raised.
  always_ff @(posedge clk) begin
    if (reset_) begin
      state       <= MEM_STATE_IDLE;
      bus_req_    <= 1'b1;
      bus_as_     <= 1'b1;
      bus_rw      <= BUS_READ;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      rd_data_q   <= '0;
    end else begin
      case (state)
        MEM_STATE_IDLE: begin
          if (acc && !flush) begin
            state       <= MEM_STATE_REQ;
            bus_req_    <= 1'b0;
            bus_rw      <= (mem_op == MEM_OP_LDW) ? BUS_READ : BUS_WRITE;
            bus_addr    <= addr;
            bus_wr_data <= wr_data;
          end
        end
        MEM_STATE_REQ: begin
          if (!bus_grnt_) begin
            state   <= MEM_STATE_ACCESS;
            bus_as_ <= 1'b0;
          end
        end
        MEM_STATE_ACCESS: begin
          if (!bus_rdy_) begin
            if (bus_rw == BUS_READ) begin
              rd_data_q <= bus_rd_data;
            end
            state    <= MEM_STATE_IDLE;
            bus_req_ <= 1'b1;
            bus_as_  <= 1'b1;
          end
        end
        default: begin
          state    <= MEM_STATE_IDLE;
          bus_req_ <= 1'b1;
          bus_as_  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: alignment check, stall decode and MEM pipeline register.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   Stall,
  input  logic                   Flush,
  input  logic [WORD_ADDR_W-1:0] EXPC,
  input  logic                   EXEn,
  input  logic                   EXBrFlag,
  input  logic [MEM_OP_W-1:0]    EXMemOp,
  input  logic [WORD_DATA_W-1:0] EXMemWrData,
  input  logic [CTRL_OP_W-1:0]   EXCtrlOp,
  input  logic [REG_ADDR_W-1:0]  EXDstAddr,
  input  logic                   EXGPRWE_,
  input  logic [ISA_EXP_W-1:0]   EXExpCode,
  input  logic [WORD_DATA_W-1:0] EXOut,
  input  logic [WORD_DATA_W-1:0] BusRdData,
  input  logic                   BusRdy_,
  input  logic                   BusGrnt_,
  output logic                   BusReq_,
  output logic                   BusAS_,
  output logic                   BusRW,
  output logic [WORD_ADDR_W-1:0] BusAddr,
  output logic [WORD_DATA_W-1:0] BusWrData,
  output logic                   Busy,
  output logic [WORD_ADDR_W-1:0] MEMPC,
  output logic                   MEMEn,
  output logic                   MEMBrFlag,
  output logic [CTRL_OP_W-1:0]   MEMCtrlOp,
  output logic [REG_ADDR_W-1:0]  MEMDstAddr,
  output logic                   MEMGPRWE_,
  output logic [ISA_EXP_W-1:0]   MEMExpCode,
  output logic [WORD_DATA_W-1:0] MEMOut
);

  logic                   mem_op_c;
  logic                   aligned_c;
  logic                   acc_c;
  logic                   misalign_c;
  mem_state_e             state;
  logic [WORD_DATA_W-1:0] rd_data_c;
  mem_reg_t               mem_q;
  mem_reg_t               mem_d;

  assign mem_op_c   = EXEn && (EXMemOp != MEM_OP_NOP);
  assign aligned_c  = (EXOut[BYTE_OFS_W-1:0] == BYTE_OFS_W'(0));
  assign acc_c      = mem_op_c && (EXExpCode == ISA_EXP_NO_EXP) && aligned_c;
  assign misalign_c = mem_op_c && !aligned_c;

  // Hold the pipeline until the bus access completes; drops in the ready cycle.
  assign Busy = ((state == MEM_STATE_IDLE) && acc_c) ||
                (state == MEM_STATE_REQ) ||
                ((state == MEM_STATE_ACCESS) && BusRdy_);

  bus_if u_bus_if (
    .clk         (clk),
    .reset_      (reset_),
    .acc         (acc_c),
    .flush       (Flush),
    .mem_op      (EXMemOp),
    .addr        (EXOut[WORD_DATA_W-1:BYTE_OFS_W]),
    .wr_data     (EXMemWrData),
    .bus_rd_data (BusRdData),
    .bus_rdy_    (BusRdy_),
    .bus_grnt_   (BusGrnt_),
    .bus_req_    (BusReq_),
    .bus_as_     (BusAS_),
    .bus_rw      (BusRW),
    .bus_addr    (BusAddr),
    .bus_wr_data (BusWrData),
    .state       (state),
    .rd_data_c   (rd_data_c)
  );

  // Next MEM register value: bubble, misalignment exception, or pass-through with result select.
  always_comb begin
    mem_d          = mem_bubble();
    mem_d.pc       = EXPC;
    mem_d.en       = EXEn;
    mem_d.br_flag  = EXBrFlag;
    mem_d.ctrl_op  = EXCtrlOp;
    mem_d.dst_addr = EXDstAddr;
    mem_d.gpr_we_  = EXGPRWE_;
    mem_d.exp_code = EXExpCode;
    case (EXMemOp)
      MEM_OP_LDW: mem_d.out = rd_data_c;
      MEM_OP_STW: mem_d.out = '0;
      default:    mem_d.out = EXOut;
    endcase
    if (Flush) begin
      mem_d = mem_bubble();
    end else if (misalign_c && (EXExpCode == ISA_EXP_NO_EXP)) begin
      mem_d.ctrl_op  = CTRL_OP_NOP;
      mem_d.dst_addr = '0;
      mem_d.gpr_we_  = 1'b1;
      mem_d.exp_code = ISA_EXP_MISS_ALIGN;
      mem_d.out      = '0;
    end
  end

  // MEM pipeline register; loads only when the pipeline advances.
  always_ff @(posedge clk) begin
    if (reset_) begin
      mem_q <= mem_bubble();
    end else if (!Stall && !Busy) begin
      mem_q <= mem_d;
    end
  end

  assign MEMPC      = mem_q.pc;
  assign MEMEn      = mem_q.en;
  assign MEMBrFlag  = mem_q.br_flag;
  assign MEMCtrlOp  = mem_q.ctrl_op;
  assign MEMDstAddr = mem_q.dst_addr;
  assign MEMGPRWE_  = mem_q.gpr_we_;
  assign MEMExpCode = mem_q.exp_code;
  assign MEMOut     = mem_q.out;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline. Sits between the EX pipeline register and the write-back/control stage. It consumes the EX-register outputs, runs loads and stores on the shared bus through a request/grant/ready handshake, and detects misaligned accesses. Its result is held in its own MEM pipeline register, and it raises `Busy` to stall the pipeline while a bus transaction is outstanding.

## Interface
Parameters: none. Widths come from the shared defines.
- `WORD_DATA_W` = 32
- `WORD_ADDR_W` = 30
- `REG_ADDR_W` = 5
- `MEM_OP_BUS` = 2 bits: NOP, LDW, STW
- `CTRL_OP_BUS` = 2 bits
- `ISA_EXP_BUS` = 3 bits

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset_`  in  1  reset. **Synchronous, active-high**: `reset_`=1 at a rising edge resets the block. The port name is kept per codebase; the polarity is high.
- `Stall`  in  1  hold the MEM register and do not accept new work.
- `Flush`  in  1  load a bubble into the MEM register.
- `EXPC`  in  30  PC of the instruction.
- `EXEn`  in  1  instruction valid.
- `EXBrFlag`  in  1  branch flag, passed through.
- `EXMemOp`  in  2  memory operation.
- `EXMemWrData`  in  32  store data.
- `EXCtrlOp`  in  2  control operation, passed through.
- `EXDstAddr`  in  5  destination register.
- `EXGPRWE_`  in  1  register write enable, active-low.
- `EXExpCode`  in  3  exception code.
- `EXOut`  in  32  ALU result; byte address when a memory op is present.
- `BusRdData`  in  32  bus read data.
- `BusRdy_`  in  1  bus ready, active-low.
- `BusGrnt_`  in  1  bus grant, active-low.
- `BusReq_`  out  1  bus request, active-low.
- `BusAS_`  out  1  address strobe, active-low.
- `BusRW`  out  1  1 = read, 0 = write.
- `BusAddr`  out  30  word address.
- `BusWrData`  out  32  store data.
- `Busy`  out  1  combinational; stalls the pipeline.
- `MEMPC`, `MEMEn`, `MEMBrFlag`, `MEMCtrlOp`, `MEMDstAddr`, `MEMGPRWE_`, `MEMExpCode`, `MEMOut`  out  (30, 1, 1, 2, 5, 1, 3, 32)  MEM pipeline register.

## Operation
- **Access condition.**
  - `Acc` = `EXEn` and `EXMemOp` ≠ NOP and `EXExpCode` = NO_EXP and `EXOut[1:0]` = 0.
  - `MisAlign` = `EXEn` and `EXMemOp` ≠ NOP and `EXOut[1:0]` ≠ 0.
- **Bus address.** `BusAddr` = `EXOut[31:2]`. `BusWrData` = `EXMemWrData`. `BusRW` = 1 for LDW, 0 for STW.
- **FSM states.** IDLE, REQ, ACCESS.
  - IDLE:
    - If `Acc` and not `Flush`: assert `BusReq_`=0 and go to REQ.
    - If `Acc` and `BusGrnt_`=0 is already low this cycle: still go to REQ; there is no same-cycle strobe.
  - REQ:
    - Hold `BusReq_`=0.
    - When `BusGrnt_`=0, go to ACCESS.
  - ACCESS:
    - Hold `BusReq_`=0 and `BusAS_`=0, with address, RW and data stable.
    - When `BusRdy_`=0: capture `BusRdData` (loads only) into a read-data register, release `BusReq_` and `BusAS_`, and return to IDLE.
- **Busy.** `Busy` = (IDLE and `Acc`) or REQ or (ACCESS and `BusRdy_`=1).
  - `Busy` drops in the cycle `BusRdy_`=0 is sampled, so the MEM register loads on that edge.
- **MEM register update** (when not `Stall` and not `Busy`), in priority order:
  1. `Flush`: bubble. PC=0, En=0, BrFlag=0, CtrlOp=NOP, DstAddr=0, GPRWE_=1, ExpCode=NO_EXP, Out=0.
  2. `MisAlign` and `EXExpCode`=NO_EXP: pass PC/En/BrFlag; CtrlOp=NOP, DstAddr=0, GPRWE_=1, ExpCode=MISS_ALIGN, Out=0. No bus activity.
  3. Otherwise: pass all EX fields through.
     - `MEMOut` = `BusRdData` if LDW completed this cycle.
     - `MEMOut` = 0 for STW.
     - `MEMOut` = `EXOut` for NOP.
- **Stall.** `Stall`=1 holds the MEM register. An in-flight bus transaction always runs to completion regardless of `Stall`/`Flush`.
- **Flush mid-transaction.** The transaction completes on the bus, but its result is discarded and a bubble is loaded.
- **Reset.** FSM=IDLE. `BusReq_`=1, `BusAS_`=1, `BusRW`=1, `BusAddr`=0, `BusWrData`=0. All MEM outputs take bubble values. Reset mid-transaction abandons the bus cycle immediately.

## Timing
- Minimum load/store latency: the access is seen at cycle 0; REQ at cycle 1; ACCESS at cycle 2, with the grant sampled in cycle 1.
  - With `BusRdy_`=0 in cycle 2, the MEM register loads at the end of cycle 2.
  - `Busy` is high in cycles 0–1 and low in cycle 2.
- Each wait state (`BusGrnt_` or `BusRdy_` high) adds exactly one cycle.
- Non-memory and misaligned instructions take 1 cycle, with `Busy`=0.
- All bus outputs and MEM outputs are registered, except `Busy`.

## Structure
- Shared constants belong in the `cpu.vh`/`isa.vh` package:
  - `MEM_OP_*`
  - `ISA_EXP_MISS_ALIGN`
  - `BUS_READ`/`BUS_WRITE`
  - FSM encodings `MEM_STATE_IDLE`/`REQ`/`ACCESS`
- One sub-module: `bus_if`, holding the FSM, handshake and read-data capture. `mem_stage` holds the alignment check, `Busy` decode and MEM register.

## Test plan
- **Simple ALU result.** `EXMemOp`=NOP, `EXOut`=0x1234, `EXGPRWE_`=0 → next edge `MEMOut`=0x1234, `MEMGPRWE_`=0, `Busy`=0, `BusReq_`=1.
- **Load with no waits.** LDW with `EXOut`=0x100; grant and ready immediate; `BusRdData`=0xDEADBEEF → `BusAddr`=0x40, `BusRW`=1, `Busy` high 2 cycles, then `MEMOut`=0xDEADBEEF.
- **Store with waits.** STW, data 0xA5A5A5A5, addr 0x204; `BusRdy_` held high 3 cycles → `BusRW`=0, `BusWrData` stable throughout, `Busy` high 5 cycles, then `MEMOut`=0.
- **Misaligned load.** LDW with `EXOut`=0x102 → no `BusReq_`; `MEMExpCode`=MISS_ALIGN, `MEMGPRWE_`=1, `MEMPC`=`EXPC`.
- **Flush mid-load.** `Flush`=1 during ACCESS → the bus cycle completes; the MEM register takes bubble values (En=0, GPRWE_=1).
- **Reset mid-store.** `reset_`=1 during ACCESS → next edge FSM=IDLE, `BusAS_`=1, `BusReq_`=1, all MEM outputs at bubble values.
